rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one datapath resource (bus port, memory port, functional unit) among NUM_REQ requesters.
- Selects one requester, holds that grant locked until the resource signals completion, then rotates priority.
- Drives both a grant index and a one-hot grant vector, so the rest of the design can steer select lines and per-requester enables directly.

---
 rtl/arbiter_pkg.sv | 12 +
 rtl/rr_arbiter_if.sv | 25 ++
 rtl/rr_arbiter_demux.sv | 16 +
 rtl/rr_arbiter.sv | 87 ++++++++
 tb/tb_rr_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Holds the arbiter state encoding and the modulo-n wrap used by the pointer and the search.
package arbiter_pkg;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   // Wrapped increment modulo n, so counts that are not powers of two never yield idx >= n.
   function automatic int next_idx(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Requester-side bundle of the round-robin arbiter. Signal names are seen from the arbiter side.
// i_req is level-sensitive and may change on any cycle; a grant is held while o_valid=1 and is
// released only by a one-cycle i_done pulse. o_grant is one-hot when o_valid=1 and zero otherwise.
interface rr_arbiter_if #(
   parameter int NUM_REQ = 5
) ();
   localparam int IDX_BITS = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]      i_req;
   logic                    i_done;
   logic                    o_valid;
   logic [IDX_BITS-1:0]     o_grant_idx;
   logic [NUM_REQ-1:0]      o_grant;
   arbiter_pkg::arb_state_t o_dbg_state;

   modport slave (
      input  i_req, i_done,
      output o_valid, o_grant_idx, o_grant, o_dbg_state
   );

   modport master (
      output i_req, i_done,
      input  o_valid, o_grant_idx, o_grant, o_dbg_state
   );
endinterface

// File: rtl/rr_arbiter_demux.sv
// Index-to-one-hot decoder with an enable: all outputs low when disabled.
module rr_arbiter_demux #(
   parameter int NUM_OUTPUTS = 5,
   parameter int SEL_BITS    = $clog2(NUM_OUTPUTS)
) (
   input  logic [SEL_BITS-1:0]    i_select,
   input  logic                   i_enable,
   output logic [NUM_OUTPUTS-1:0] o_out
);

   always_comb begin
      o_out = '0;
      if (i_enable) o_out[i_select] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: locks a grant until i_done, then rotates priority past the finisher.
// A finishing transaction can hand straight to the next requester on the same edge.
module rr_arbiter
   import arbiter_pkg::*;
#(
   parameter int NUM_REQ = 5
) (
   input logic          i_clk,
   input logic          i_rst,
   rr_arbiter_if.slave  arb
);
   localparam int IDX_BITS = $clog2(NUM_REQ);

   arb_state_t          r_state;
   logic                r_valid;
   logic [IDX_BITS-1:0] r_grant_idx;
   logic [IDX_BITS-1:0] r_ptr;

   logic                w_any;
   logic [IDX_BITS-1:0] w_ptr_next;
   logic [IDX_BITS-1:0] w_base;
   logic [IDX_BITS-1:0] w_sel;
   logic [IDX_BITS-1:0] w_k;
   logic                w_found;

   assign w_any      = |arb.i_req;
   assign w_ptr_next = IDX_BITS'(next_idx(int'(r_grant_idx), NUM_REQ));
   // A re-grant on completion searches from the rotated pointer, not the stored one.
   assign w_base     = (r_state == BUSY) ? w_ptr_next : r_ptr;

   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_k     = w_base;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && arb.i_req[w_k]) begin
            w_found = 1'b1;
            w_sel   = w_k;
         end
         w_k = IDX_BITS'(next_idx(int'(w_k), NUM_REQ));
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_valid     <= 1'b0;
         r_grant_idx <= '0;
         r_ptr       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state     <= BUSY;
                  r_valid     <= 1'b1;
                  r_grant_idx <= w_sel;
               end
            end
            BUSY: begin
               if (arb.i_done) begin
                  r_ptr <= w_ptr_next;
                  if (w_any) begin
                     r_grant_idx <= w_sel;
                  end else begin
                     r_state <= IDLE;
                     r_valid <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   rr_arbiter_demux #(
      .NUM_OUTPUTS (NUM_REQ),
      .SEL_BITS    (IDX_BITS)
   ) u_demux (
      .i_select (r_grant_idx),
      .i_enable (r_valid),
      .o_out    (arb.o_grant)
   );

   assign arb.o_valid     = r_valid;
   assign arb.o_grant_idx = r_grant_idx;
   assign arb.o_dbg_state = r_state;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios followed by random traffic, checked cycle by cycle
// against a reference model of the round-robin rules.
module tb_rr_arbiter;
   localparam int N  = 5;
   localparam int IB = $clog2(N);
   localparam int EW = 1 + IB + N;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rr_arbiter_if #(.NUM_REQ(N)) arb ();

   rr_arbiter #(.NUM_REQ(N)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .arb   (arb)
   );

   always #5 clk = ~clk;

   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   bit mon_en   = 1'b0;

   // Reference model state
   int m_ptr  = 0;
   int m_idx  = 0;
   bit m_busy = 1'b0;

   function automatic int model_sel(input int p, input logic [N-1:0] r);
      for (int o = 0; o < N; o++) begin
         int k;
         k = (p + o) % N;
         if (r[k]) return k;
      end
      return -1;
   endfunction

   task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got valid=%0b idx=%0d grant=%b, expected valid=%0b idx=%0d grant=%b",
                  name, $time, got[EW-1], got[N+IB-1:N], got[N-1:0],
                  exp[EW-1], exp[N+IB-1:N], exp[N-1:0]);
      end
   endtask

   function automatic logic [EW-1:0] model_out();
      logic [N-1:0] g;
      g = m_busy ? (N'(1) << m_idx) : '0;
      return {m_busy, IB'(m_idx), g};
   endfunction

   function automatic logic [EW-1:0] dut_out();
      return {arb.o_valid, arb.o_grant_idx, arb.o_grant};
   endfunction

   task automatic model_reset();
      m_ptr  = 0;
      m_idx  = 0;
      m_busy = 1'b0;
   endtask

   // One clock of stimulus; the expected outputs after the coming edge are queued.
   task automatic cycle(input logic [N-1:0] req, input logic done);
      @(negedge clk);
      arb.i_req  = req;
      arb.i_done = done;
      if (m_busy) begin
         if (done) begin
            m_ptr = (m_idx + 1) % N;
            if (req != '0) m_idx = model_sel(m_ptr, req);
            else           m_busy = 1'b0;
         end
      end else if (req != '0) begin
         m_idx  = model_sel(m_ptr, req);
         m_busy = 1'b1;
      end
      exp_q.push_back(model_out());
      mon_en = 1'b1;
   endtask

   // Reset raised between edges: outputs must clear before any clock edge.
   task automatic reset_mid();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("async_reset_clear", dut_out(), model_out());
      exp_q.push_back(model_out());
      @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL queue_underflow at %0t: got empty queue, expected an entry", $time);
            end else begin
               logic [EW-1:0] e;
               e = exp_q.pop_front();
               check("cycle_out", dut_out(), e);
            end
         end
      end
   end

   initial begin : driver
      arb.i_req  = '0;
      arb.i_done = 1'b0;
      rst        = 1'b1;
      repeat (3) @(negedge clk);
      model_reset();
      check("reset_values", dut_out(), model_out());
      rst = 1'b0;

      // Single request pulse, grant holds until done
      cycle(5'b10100, 1'b0);
      repeat (3) cycle(5'b00000, 1'b0);
      cycle(5'b00000, 1'b1);
      cycle(5'b00000, 1'b0);

      // All requesting, done every third cycle: back-to-back rotation
      reset_mid();
      for (int i = 0; i < 18; i++) cycle(5'b11111, (i % 3) == 2);

      // Wrap from 4 to 0, then a lone request at 4
      reset_mid();
      cycle(5'b10000, 1'b0);
      cycle(5'b10001, 1'b1);
      cycle(5'b10000, 1'b1);
      cycle(5'b00000, 1'b0);
      cycle(5'b00000, 1'b1);

      // Only the finisher requests: it is re-granted, pointer moves past it
      cycle(5'b01000, 1'b0);
      cycle(5'b01000, 1'b1);
      cycle(5'b11001, 1'b1);
      cycle(5'b00000, 1'b1);

      // Done while idle is ignored
      cycle(5'b00000, 1'b1);
      cycle(5'b00000, 1'b1);
      cycle(5'b00000, 1'b0);

      // Reset in the middle of a transaction
      cycle(5'b00100, 1'b0);
      cycle(5'b00001, 1'b1);
      cycle(5'b11111, 1'b0);
      reset_mid();
      cycle(5'b01000, 1'b0);
      cycle(5'b00000, 1'b1);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         logic [N-1:0] r;
         r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
         cycle(r, $urandom_range(0, 2) == 0);
      end
      cycle(5'b00000, 1'b1);

      @(posedge clk);
      #2;
      mon_en = 1'b0;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
